// File: rtl/fp_arb_pkg.sv
// Shared types and helpers for the floating-point adder arbiter.
package fp_arb_pkg;

  localparam int unsigned FP_W_DEF  = 32;
  localparam int unsigned MAX_REQ   = 16;
  localparam int unsigned MAX_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } rr_pick_t;

  // First asserted bit of req[n-1:0], searching upward from ptr and wrapping.
  function automatic rr_pick_t rr_first_one(input logic [MAX_REQ-1:0]   req,
                                            input logic [MAX_IDX_W-1:0] ptr,
                                            input int unsigned          n);
    rr_pick_t    r;
    int unsigned j;
    r = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      j = 32'(ptr) + i;
      if (j >= n) begin
        j = j - n;
      end
      if ((i < n) && !r.found && req[j[MAX_IDX_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = MAX_IDX_W'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: one-hot grant and binary index of the winner.
module rr_arbiter
  import fp_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt_c,
  output logic [ID_W-1:0]    idx_c
);

  logic [MAX_REQ-1:0] req_ext;
  rr_pick_t           pick;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
    pick                   = rr_first_one(req_ext, MAX_IDX_W'(ptr), NUM_REQ);
    idx_c                  = ID_W'(pick.idx);
    gnt_c                  = '0;
    if (en && pick.found) begin
      gnt_c[idx_c] = 1'b1;
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin front end sharing one multi-cycle FP adder among NUM_REQ requesters.
// Optional watchdog on the adder's done strobe: define FP_ARB_TIMEOUT_EN.
module fp_add_arbiter
  import fp_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ     = 4,
  parameter  int unsigned FP_W        = FP_W_DEF,
  parameter  int unsigned TIMEOUT_CYC = 64,
  localparam int unsigned ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*FP_W-1:0] req_x,
  input  logic [NUM_REQ*FP_W-1:0] req_y,
  output logic                    add_start,
  output logic [FP_W-1:0]         add_x,
  output logic [FP_W-1:0]         add_y,
  input  logic                    add_done,
  input  logic [FP_W-1:0]         add_sum,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [FP_W-1:0]         rsp_sum,
  output logic                    rsp_err
);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              add_start_q, add_start_d;
  logic [FP_W-1:0]   add_x_q, add_x_d;
  logic [FP_W-1:0]   add_y_q, add_y_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [FP_W-1:0]   rsp_sum_q, rsp_sum_d;

  logic              arb_en_c;
  logic [NUM_REQ-1:0] gnt_c;
  logic [ID_W-1:0]   win_idx_c;
  logic              accept_c;

`ifdef FP_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             rsp_err_q, rsp_err_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |32'(TIMEOUT_CYC);
`endif

  // Grants only while idle and out of reset, so req_ready stays low during reset.
  assign arb_en_c = reset && (state_q == IDLE);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (ptr_q),
    .en    (arb_en_c),
    .gnt_c (gnt_c),
    .idx_c (win_idx_c)
  );

  assign accept_c = |(req_valid & gnt_c);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    add_start_d = 1'b0;
    add_x_d     = add_x_q;
    add_y_d     = add_y_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
`ifdef FP_ARB_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          add_x_d     = req_x[32'(win_idx_c) * FP_W +: FP_W];
          add_y_d     = req_y[32'(win_idx_c) * FP_W +: FP_W];
          rsp_id_d    = win_idx_c;
          add_start_d = 1'b1;
          state_d     = ISSUE;
`ifdef FP_ARB_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef FP_ARB_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      WAIT: begin
        if (add_done) begin
          rsp_sum_d   = add_sum;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
`ifdef FP_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC)) begin
          rsp_sum_d   = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
          // Next search starts just past the requester that was served.
          ptr_d = (rsp_id_q == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id_q + ID_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      add_start_q <= 1'b0;
      add_x_q     <= '0;
      add_y_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
`ifdef FP_ARB_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      add_start_q <= add_start_d;
      add_x_q     <= add_x_d;
      add_y_q     <= add_y_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
`ifdef FP_ARB_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign req_ready = gnt_c;
  assign add_start = add_start_q;
  assign add_x     = add_x_q;
  assign add_y     = add_y_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
`ifdef FP_ARB_TIMEOUT_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Randomized bench for fp_add_arbiter with a 3-cycle adder model and a transaction-level reference.
module tb_fp_add_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 32;
  localparam int unsigned TMO = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_x, req_y;
  logic           add_start, add_done;
  logic [W-1:0]   add_x, add_y, add_sum;
  logic           rsp_valid, rsp_ready, rsp_err;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_sum;

  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc      = 0;
  int          done_at  = -1;
  logic [31:0] pend_sum = '0;
  bit          spur_en  = 1'b0;
  bit          kill_done = 1'b0;
  int          mptr     = 0;
  int          opa[N];
  int          opb[N];

  always #5 clk = ~clk;

  fp_add_arbiter #(.NUM_REQ(N), .FP_W(W), .TIMEOUT_CYC(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .add_start (add_start),
    .add_x     (add_x),
    .add_y     (add_y),
    .add_done  (add_done),
    .add_sum   (add_sum),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_err   (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Exact single-precision encoding of a small non-negative integer.
  function automatic logic [31:0] i2f(input int unsigned v);
    int          e;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    e = 31;
    while (e > 0 && !v[e]) e--;
    m = 32'(v) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  function automatic int unsigned f2i(input logic [31:0] f);
    int          e;
    logic [31:0] m;
    if (f[30:23] == 8'h0) return 0;
    e = int'(f[30:23]) - 127;
    m = {8'h0, 1'b1, f[22:0]};
    return 32'(m >> (23 - e));
  endfunction

  // Reference round-robin choice: first valid requester at or after p, wrapping.
  function automatic int model_pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < int'(N); i++) begin
      int j;
      j = (p + i) % int'(N);
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // One clock; the adder model answers 3 cycles after it sees add_start.
  task automatic cycle();
    @(posedge clk);
    cyc++;
    #1;
    add_done = 1'b0;
    add_sum  = '0;
    if (add_start === 1'b1) begin
      if (!kill_done) begin
        done_at  = cyc + 3;
        pend_sum = i2f(f2i(add_x) + f2i(add_y));
      end
      if (spur_en) begin
        add_done = 1'b1;
        add_sum  = 32'hDEAD_BEEF;
      end
    end else if (cyc == done_at) begin
      add_done = 1'b1;
      add_sum  = pend_sum;
    end
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) begin
      cycle();
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_add_start", 32'(add_start), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    reset = 1'b1;
    mptr  = 0;
  endtask

  task automatic run_txn(input logic [N-1:0] v, input int hold, input bit spur,
                         input bit rand_ops, output int w);
    bit          got;
    int          lat;
    logic [31:0] ex, ey, es;
    for (int i = 0; i < int'(N); i++) begin
      if (rand_ops) begin
        opa[i] = int'($urandom_range(0, 1000));
        opb[i] = int'($urandom_range(0, 1000));
      end
      req_x[i*W +: W] = i2f(opa[i]);
      req_y[i*W +: W] = i2f(opb[i]);
    end
    spur_en   = spur;
    rsp_ready = (hold == 0);
    req_valid = v;
    w  = model_pick(v, mptr);
    ex = i2f(opa[w]);
    ey = i2f(opb[w]);
    es = i2f(opa[w] + opb[w]);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      #1;
      if (req_ready != '0) got = 1'b1;
      else cycle();
    end
    chk("accept_seen", 32'(got), 32'd1);
    if (!got) return;
    chk("grant", 32'(req_ready), 32'(1) << w);
    cycle();
    #1;
    chk("add_start", 32'(add_start), 32'd1);
    chk("add_x", add_x, ex);
    chk("add_y", add_y, ey);
    chk("ready_pulse", 32'(req_ready), 32'd0);
    chk("err_clear", 32'(rsp_err), 32'd0);
    lat = 1;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (rsp_valid) got = 1'b1;
      else begin
        cycle();
        #1;
        lat++;
      end
    end
    chk("rsp_seen", 32'(got), 32'd1);
    if (!got) return;
    chk("rsp_latency", 32'(lat), 32'd5);
    chk("rsp_id", 32'(rsp_id), 32'(w));
    chk("rsp_sum", rsp_sum, es);
    chk("rsp_err", 32'(rsp_err), 32'd0);
    for (int h = 0; h < hold; h++) begin
      cycle();
      #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_id", 32'(rsp_id), 32'(w));
      chk("hold_sum", rsp_sum, es);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    cycle();
    mptr = (w + 1) % int'(N);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w;
    int lat;
    bit got;
    reset     = 1'b0;
    req_valid = '1;
    req_x     = '0;
    req_y     = '0;
    add_done  = 1'b0;
    add_sum   = '0;
    rsp_ready = 1'b0;
    apply_reset(2);
    req_valid = '0;

    // 1.0 + 2.0 from requester 2 alone
    opa[2] = 1;
    opb[2] = 2;
    run_txn(4'b0100, 0, 1'b0, 1'b0, w);
    chk("sum_3p0", rsp_sum, 32'h4040_0000);
    req_valid = '0;

    // All requesters valid continuously from a fresh pointer
    apply_reset(2);
    for (int t = 0; t < 5; t++) run_txn(4'b1111, 0, 1'b0, 1'b1, w);

    // Response back-pressure with competing requests pending
    run_txn(4'b1111, 5, 1'b0, 1'b1, w);

    for (int t = 0; t < 40; t++) begin
      run_txn(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'b1, w);
    end

    // Reset while the adder is busy; its late done must be dropped
    req_valid = '0;
    run_txn(4'b0010, 0, 1'b0, 1'b1, w);
    req_valid = 4'b0100;
    cycle();
    req_valid = '0;
    #1;
    chk("wr_add_start", 32'(add_start), 32'd1);
    cycle();
    reset = 1'b0;
    cycle();
    cycle();
    #1;
    chk("wr_rst_start", 32'(add_start), 32'd0);
    chk("wr_rst_valid", 32'(rsp_valid), 32'd0);
    chk("wr_rst_add_x", add_x, 32'd0);
    chk("wr_rst_sum", rsp_sum, 32'd0);
    chk("wr_rst_ready", 32'(req_ready), 32'd0);
    reset = 1'b1;
    mptr  = 0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      #1;
      chk("wr_no_rsp", 32'(rsp_valid), 32'd0);
      chk("wr_no_start", 32'(add_start), 32'd0);
    end
    run_txn(4'b1111, 0, 1'b0, 1'b1, w);

`ifdef FP_ARB_TIMEOUT_EN
    req_valid = '0;
    kill_done = 1'b1;
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    w = model_pick(4'b1000, mptr);
    #1;
    chk("tmo_grant", 32'(req_ready), 32'(1) << w);
    cycle();
    req_valid = '0;
    #1;
    lat = 1;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      if (rsp_valid) got = 1'b1;
      else begin
        cycle();
        #1;
        lat++;
      end
    end
    chk("tmo_seen", 32'(got), 32'd1);
    chk("tmo_latency", 32'(lat), 32'(TMO + 3));
    chk("tmo_sum", rsp_sum, 32'd0);
    chk("tmo_err", 32'(rsp_err), 32'd1);
    chk("tmo_id", 32'(rsp_id), 32'(w));
    rsp_ready = 1'b1;
    cycle();
    mptr = (w + 1) % int'(N);
    kill_done = 1'b0;
    run_txn(4'b0001, 0, 1'b0, 1'b1, w);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
